alu_control: RTL and testbench

- ALU control decoder for the RV32I core; sits between the main control unit and the ALU in the execute stage.
- Maps the 2-bit ALUOp class from main control, plus instruction funct3/funct7, to a 4-bit ALU operation code.
- Output is registered: one clock of latency, so it aligns with the pipelined operand registers.
- Also flags R-type/I-type funct encodings that are not legal RV32I.

---
 rtl/alu_control_if.sv | 27 ++
 rtl/alu_control.sv | 86 ++++++++
 tb/tb_alu_control.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_control_if.sv
// Decode bus between the main control unit / instruction fields and the
// ALU control decoder. master drives the decode request, slave returns the ALU op.
interface alu_control_if #(
  parameter int CTRL_W = 4
);
  logic [1:0]        ALUOp;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [CTRL_W-1:0] ALUCtrl;
  logic              illegal;

  modport master (
    output ALUOp,
    output funct7,
    output funct3,
    input  ALUCtrl,
    input  illegal
  );

  modport slave (
    input  ALUOp,
    input  funct7,
    input  funct3,
    output ALUCtrl,
    output illegal
  );
endinterface

// File: rtl/alu_control.sv
// RV32I ALU control decoder: maps ALUOp class plus funct3/funct7 to a 4-bit ALU op,
// registered with one cycle of latency, and flags funct encodings that are not legal RV32I.
module alu_control #(
  parameter int CTRL_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_control_if.slave bus
);

  localparam logic [CTRL_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] OP_SLL  = 4'b0010;
  localparam logic [CTRL_W-1:0] OP_SLT  = 4'b0011;
  localparam logic [CTRL_W-1:0] OP_SLTU = 4'b0100;
  localparam logic [CTRL_W-1:0] OP_XOR  = 4'b0101;
  localparam logic [CTRL_W-1:0] OP_SRL  = 4'b0110;
  localparam logic [CTRL_W-1:0] OP_SRA  = 4'b0111;
  localparam logic [CTRL_W-1:0] OP_OR   = 4'b1000;
  localparam logic [CTRL_W-1:0] OP_AND  = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [CTRL_W-1:0] ctrl_d;
  logic              illegal_d;
  logic              f7_base;
  logic              f7_alt;

  assign f7_base = (bus.funct7 == F7_BASE);
  assign f7_alt  = (bus.funct7 == F7_ALT);

  always_comb begin
    ctrl_d    = OP_ADD;
    illegal_d = 1'b0;
    unique case (bus.ALUOp)
      2'b00: ctrl_d = OP_ADD;
      2'b01: ctrl_d = OP_SUB;
      2'b10: begin
        // On illegal encodings funct7[5] still picks the alternate op for 000/101.
        unique case (bus.funct3)
          3'b000: ctrl_d = bus.funct7[5] ? OP_SUB : OP_ADD;
          3'b001: ctrl_d = OP_SLL;
          3'b010: ctrl_d = OP_SLT;
          3'b011: ctrl_d = OP_SLTU;
          3'b100: ctrl_d = OP_XOR;
          3'b101: ctrl_d = bus.funct7[5] ? OP_SRA : OP_SRL;
          3'b110: ctrl_d = OP_OR;
          3'b111: ctrl_d = OP_AND;
        endcase
        illegal_d = !(f7_base || f7_alt) ||
                    (f7_alt && (bus.funct3 != 3'b000) && (bus.funct3 != 3'b101));
      end
      2'b11: begin
        // funct7 is immediate data for everything except the shifts.
        unique case (bus.funct3)
          3'b000: ctrl_d = OP_ADD;
          3'b001: begin
            ctrl_d    = OP_SLL;
            illegal_d = !f7_base;
          end
          3'b010: ctrl_d = OP_SLT;
          3'b011: ctrl_d = OP_SLTU;
          3'b100: ctrl_d = OP_XOR;
          3'b101: begin
            ctrl_d    = bus.funct7[5] ? OP_SRA : OP_SRL;
            illegal_d = !(f7_base || f7_alt);
          end
          3'b110: ctrl_d = OP_OR;
          3'b111: ctrl_d = OP_AND;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ALUCtrl <= OP_ADD;
      bus.illegal <= 1'b0;
    end else begin
      bus.ALUCtrl <= ctrl_d;
      bus.illegal <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Directed-vector bench for alu_control: reset, load/branch, R-type sweep,
// illegal encodings, I-type cases and an asynchronous reset mid-stream.
module tb_alu_control;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  alu_control_if #(.CTRL_W(4)) bus ();

  alu_control #(.CTRL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.ALUOp  = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  // Drive one decode, clock it through, sample 1 time unit after the edge.
  task automatic apply(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [3:0] exp_ctrl, input logic exp_ill);
    drive(op, f3, f7);
    @(posedge clk);
    #1;
    check({tag, ".ctrl"}, bus.ALUCtrl, exp_ctrl);
    check({tag, ".ill"}, {3'b000, bus.illegal}, {3'b000, exp_ill});
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b1;
    drive(2'b10, 3'b111, 7'b0000000);

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst.ctrl", bus.ALUCtrl, 4'b0000);
    check("rst.ill", {3'b000, bus.illegal}, 4'b0000);
    @(posedge clk);
    #1;
    check("rst_hold.ctrl", bus.ALUCtrl, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel.ctrl", bus.ALUCtrl, 4'b1001);
    check("rst_rel.ill", {3'b000, bus.illegal}, 4'b0000);

    // Load/store and branch ignore funct fields.
    apply("ld0", 2'b00, 3'b101, 7'b0100000, 4'b0000, 1'b0);
    apply("ld1", 2'b00, 3'b111, 7'b1111111, 4'b0000, 1'b0);
    apply("br0", 2'b01, 3'b000, 7'b0000000, 4'b0001, 1'b0);
    apply("br1", 2'b01, 3'b110, 7'b1010101, 4'b0001, 1'b0);

    // R-type legal sweep, back to back.
    apply("r_add",  2'b10, 3'b000, 7'b0000000, 4'b0000, 1'b0);
    apply("r_sub",  2'b10, 3'b000, 7'b0100000, 4'b0001, 1'b0);
    apply("r_sll",  2'b10, 3'b001, 7'b0000000, 4'b0010, 1'b0);
    apply("r_slt",  2'b10, 3'b010, 7'b0000000, 4'b0011, 1'b0);
    apply("r_sltu", 2'b10, 3'b011, 7'b0000000, 4'b0100, 1'b0);
    apply("r_xor",  2'b10, 3'b100, 7'b0000000, 4'b0101, 1'b0);
    apply("r_srl",  2'b10, 3'b101, 7'b0000000, 4'b0110, 1'b0);
    apply("r_sra",  2'b10, 3'b101, 7'b0100000, 4'b0111, 1'b0);
    apply("r_or",   2'b10, 3'b110, 7'b0000000, 4'b1000, 1'b0);
    apply("r_and",  2'b10, 3'b111, 7'b0000000, 4'b1001, 1'b0);

    // R-type illegal encodings.
    apply("ri_f7",   2'b10, 3'b000, 7'b0000001, 4'b0000, 1'b1);
    apply("ri_xor",  2'b10, 3'b100, 7'b0100000, 4'b0101, 1'b1);
    apply("ri_sub",  2'b10, 3'b000, 7'b0100001, 4'b0001, 1'b1);
    apply("ri_srl",  2'b10, 3'b101, 7'b1000000, 4'b0110, 1'b1);
    apply("ri_sll",  2'b10, 3'b001, 7'b0100000, 4'b0010, 1'b1);

    // I-type.
    apply("i_add",   2'b11, 3'b000, 7'b0100000, 4'b0000, 1'b0);
    apply("i_sra",   2'b11, 3'b101, 7'b0100000, 4'b0111, 1'b0);
    apply("i_srl",   2'b11, 3'b101, 7'b0000000, 4'b0110, 1'b0);
    apply("i_slli",  2'b11, 3'b001, 7'b0100000, 4'b0010, 1'b1);
    apply("i_sll",   2'b11, 3'b001, 7'b0000000, 4'b0010, 1'b0);
    apply("i_srx",   2'b11, 3'b101, 7'b0110000, 4'b0111, 1'b1);
    apply("i_slt",   2'b11, 3'b010, 7'b1111111, 4'b0011, 1'b0);
    apply("i_sltu",  2'b11, 3'b011, 7'b0100000, 4'b0100, 1'b0);
    apply("i_xor",   2'b11, 3'b100, 7'b1000001, 4'b0101, 1'b0);
    apply("i_or",    2'b11, 3'b110, 7'b0100000, 4'b1000, 1'b0);
    apply("i_and",   2'b11, 3'b111, 7'b1111111, 4'b1001, 1'b0);

    // Asynchronous reset between edges in the middle of a sweep.
    apply("m_or",  2'b10, 3'b110, 7'b0000000, 4'b1000, 1'b0);
    apply("m_ill", 2'b10, 3'b010, 7'b0100000, 4'b0011, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst.ctrl", bus.ALUCtrl, 4'b0000);
    check("mrst.ill", {3'b000, bus.illegal}, 4'b0000);
    #2 rst_n = 1'b1;
    apply("m_sra", 2'b10, 3'b101, 7'b0100000, 4'b0111, 1'b0);
    apply("m_and", 2'b10, 3'b111, 7'b0000000, 4'b1001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
